// File: rtl/systolic_pe_banked.sv
// Output-stationary systolic PE with several accumulator banks, so one bank can
// accumulate while another drains along the cIn -> cOut chain.

// Small-float multiply-add. A product is added into a two's-complement fixed-point
// accumulator whose LSB weighs the smallest normal product. An operand with a zero
// exponent field counts as zero.
module FloatMultiplyAdd_POC_combinational #(
  parameter int EXP_IN_A    = 3,
  parameter int FRAC_IN_A   = 2,
  parameter int EXP_IN_B    = 3,
  parameter int FRAC_IN_B   = 2,
  parameter int ACC_DESIRED = 32
) (
  input  logic [EXP_IN_A+FRAC_IN_A:0] a,
  input  logic [EXP_IN_B+FRAC_IN_B:0] b,
  input  logic [ACC_DESIRED-1:0]      accIn,
  output logic [ACC_DESIRED-1:0]      cNew
);
  localparam int SW = ((EXP_IN_A > EXP_IN_B) ? EXP_IN_A : EXP_IN_B) + 1;

  logic [EXP_IN_A-1:0]    ea;
  logic [EXP_IN_B-1:0]    eb;
  logic [FRAC_IN_A:0]     ma;
  logic [FRAC_IN_B:0]     mb;
  logic [SW-1:0]          shamt;
  logic [ACC_DESIRED-1:0] prod;
  logic [ACC_DESIRED-1:0] mag;
  logic [ACC_DESIRED-1:0] term;

  // Decode operands, scale the mantissa product by the combined exponent, apply sign.
  always_comb begin
    ea    = a[FRAC_IN_A +: EXP_IN_A];
    eb    = b[FRAC_IN_B +: EXP_IN_B];
    ma    = {1'b1, a[FRAC_IN_A-1:0]};
    mb    = {1'b1, b[FRAC_IN_B-1:0]};
    prod  = ACC_DESIRED'(ma) * ACC_DESIRED'(mb);
    shamt = SW'(ea) + SW'(eb) - SW'(2);
    if ((ea == '0) || (eb == '0)) begin
      mag = '0;
    end else begin
      mag = prod << shamt;
    end
    if (a[EXP_IN_A+FRAC_IN_A] ^ b[EXP_IN_B+FRAC_IN_B]) begin
      term = ACC_DESIRED'(0) - mag;
    end else begin
      term = mag;
    end
    cNew = accIn + term;
  end
endmodule

module systolic_pe_banked #(
  parameter int EXP_IN_A    = 3,
  parameter int FRAC_IN_A   = 2,
  parameter int EXP_IN_B    = 3,
  parameter int FRAC_IN_B   = 2,
  parameter int ACC_DESIRED = 32,
  parameter int NUM_BANKS   = 2,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [EXP_IN_A+FRAC_IN_A:0]   aIn,
  input  logic [EXP_IN_B+FRAC_IN_B:0]   bIn,
  input  logic [ACC_DESIRED-1:0]        cIn,
  output logic [EXP_IN_A+FRAC_IN_A:0]   aOut,
  output logic [EXP_IN_B+FRAC_IN_B:0]   bOut,
  output logic [ACC_DESIRED-1:0]        cOut,
  input  logic                          enableMul,
  input  logic [BW-1:0]                 macBank,
  input  logic                          enableShiftOut,
  input  logic [BW-1:0]                 shiftBank,
  input  logic                          clearEn,
  input  logic [BW-1:0]                 clearBank,
  output logic                          conflict,
  output logic                          badSel
);
  logic [ACC_DESIRED-1:0] acc [NUM_BANKS];
  logic [ACC_DESIRED-1:0] mac_acc;
  logic [ACC_DESIRED-1:0] c_new;
  logic [NUM_BANKS-1:0]   mac_hit;
  logic [NUM_BANKS-1:0]   shift_hit;
  logic [NUM_BANKS-1:0]   clear_hit;
  logic                   mac_ok;
  logic                   shift_ok;
  logic                   clear_ok;
  logic                   collide;
  logic                   bad;

  // Per-bank hit decode; an out-of-range select hits no bank, so it reads as zero.
  always_comb begin
    mac_acc   = '0;
    cOut      = '0;
    mac_hit   = '0;
    shift_hit = '0;
    clear_hit = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      mac_hit[i]   = enableMul && (macBank == BW'(i));
      shift_hit[i] = enableShiftOut && (shiftBank == BW'(i));
      clear_hit[i] = clearEn && (clearBank == BW'(i));
      mac_acc      = (macBank == BW'(i)) ? acc[i] : mac_acc;
      cOut         = (shiftBank == BW'(i)) ? acc[i] : cOut;
    end
    mac_ok   = ({1'b0, macBank} < (BW+1)'(NUM_BANKS));
    shift_ok = ({1'b0, shiftBank} < (BW+1)'(NUM_BANKS));
    clear_ok = ({1'b0, clearBank} < (BW+1)'(NUM_BANKS));
    collide  = (|(mac_hit & shift_hit)) || (|(mac_hit & clear_hit)) || (|(shift_hit & clear_hit));
    bad      = (enableMul && !mac_ok) || (enableShiftOut && !shift_ok) || (clearEn && !clear_ok);
  end

  FloatMultiplyAdd_POC_combinational #(
    .EXP_IN_A   (EXP_IN_A),
    .FRAC_IN_A  (FRAC_IN_A),
    .EXP_IN_B   (EXP_IN_B),
    .FRAC_IN_B  (FRAC_IN_B),
    .ACC_DESIRED(ACC_DESIRED)
  ) u_mac (
    .a    (aIn),
    .b    (bIn),
    .accIn(mac_acc),
    .cNew (c_new)
  );

  // Bank writes resolve clear > shift > MAC per bank; flags are sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        acc[i] <= '0;
      end
      aOut     <= '0;
      bOut     <= '0;
      conflict <= 1'b0;
      badSel   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (clear_hit[i]) begin
          acc[i] <= '0;
        end else if (shift_hit[i]) begin
          acc[i] <= cIn;
        end else if (mac_hit[i]) begin
          acc[i] <= c_new;
        end else begin
          acc[i] <= acc[i];
        end
      end
      if (enableMul) begin
        aOut <= aIn;
        bOut <= bIn;
      end
      conflict <= conflict | collide;
      badSel   <= badSel | bad;
    end
  end
endmodule
